// File: rtl/jam_lane_sched.sv
// Jam-mode lane scheduler: grants one jammed lane at a time, round-robin,
// with a fixed green time followed by an all-off clearance interval.
module jam_lane_sched #(
    parameter int GREEN_CYC = 20,
    parameter int CLEAR_CYC = 3,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       jam_op_en,
    input  logic       jam_counter_en,
    input  logic       traffic_jam_0,
    input  logic       traffic_jam_1,
    input  logic       traffic_jam_2,
    input  logic       traffic_jam_3,
    output logic       allow_0_jam,
    output logic       allow_1_jam,
    output logic       allow_2_jam,
    output logic       allow_3_jam,
    output logic [1:0] cur_lane,
    output logic       busy
);

    generate
        if (GREEN_CYC < 1 || CLEAR_CYC < 1) begin : g_bad_cycles
            $error("jam_lane_sched: GREEN_CYC and CLEAR_CYC must be >= 1");
        end
        if (((GREEN_CYC - 1) >> CNT_W) != 0 || ((CLEAR_CYC - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
            $error("jam_lane_sched: CNT_W too narrow for GREEN_CYC/CLEAR_CYC");
        end
    endgenerate

    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        GREEN,
        CLEAR
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       last_lane, last_nx;
    logic [3:0]       req;
    logic [3:0]       allow_q;
    logic             found;
    logic [1:0]       pick;

    assign req = {traffic_jam_3, traffic_jam_2, traffic_jam_1, traffic_jam_0};

    // Round-robin search starting just after the last served lane; the
    // fourth candidate wraps back to last_lane itself.
    always_comb begin : search
        logic [1:0] cand;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        found = 1'b0;
        pick  = last_lane;
        cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_lane + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin : next_state
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last_lane;
        if (!jam_op_en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                IDLE: state_nx = SELECT;
                SELECT: begin
                    if (found) begin
                        state_nx = GREEN;
                        last_nx  = pick;
                        cnt_nx   = '0;
                    end
                end
                GREEN: begin
                    if (jam_counter_en) begin
                        if (cnt == GREEN_LAST) begin
                            state_nx = CLEAR;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (jam_counter_en) begin
                        if (cnt == CLEAR_LAST) begin
                            state_nx = SELECT;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state decode, so they line up
    // cycle-for-cycle with the state register and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments; reset is asynchronous so grants drop at once.
            state     <= IDLE;
            cnt       <= '0;
            last_lane <= 2'd3;
            allow_q   <= '0;
            cur_lane  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            last_lane <= last_nx;
            if (state_nx == GREEN) begin
                allow_q  <= 4'b0001 << last_nx;
                cur_lane <= last_nx;
                busy     <= 1'b1;
            end else begin
                allow_q  <= '0;
                cur_lane <= '0;
                busy     <= 1'b0;
            end
        end
    end

    assign allow_0_jam = allow_q[0];
    assign allow_1_jam = allow_q[1];
    assign allow_2_jam = allow_q[2];
    assign allow_3_jam = allow_q[3];

endmodule
